uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter. Sends one 8N1 frame per accepted byte: 1 start bit, 8 data bits LSB-first, 1 stop bit.
- Bit timing comes from the system clock.
- Sits between a byte-producing host and the physical TX pin.
- Uses a simple enable/busy handshake.

Parameters:
- BIT_RATE, 9600: line bit rate in bits/s.
- CLK_HZ, 50000000: system clock frequency in Hz.
- PAYLOAD_BITS, 8: data bits per frame.
- STOP_BITS, 1: stop bits per frame.
- CYCLES_PER_BIT (localparam), CLK_HZ/BIT_RATE (integer divide, 5208 at defaults): clock cycles per bit. Must be hierarchically readable under exactly this name.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- resetn  input  1  synchronous, active-high reset. Asserted when 1; sampled only on the rising edge of clk.
- uart_tx_en  input  1  request to send uart_tx_data. Level-sensitive.
- uart_tx_data  input  8  byte to transmit.
- uart_tx_busy  output  1  high while a frame is in progress.
- uart_txd  output  1  serial line. Idles high. Driven from a register (glitch-free).

Behaviour:
- Reset (resetn=1 at a clk edge):
  - next state IDLE; uart_txd=1; uart_tx_busy=0.
  - cycle counter, bit counter and data shift register cleared.
  - Takes effect mid-frame too: the line returns high on the next edge and the partial frame is abandoned.
- States: IDLE, START, DATA, STOP.
- IDLE:
  - uart_txd=1, busy=0.
  - If uart_tx_en=1 at an edge, latch uart_tx_data into the shift register and go to START. busy=1 from that edge on.
- START:
  - uart_txd=0 for exactly CYCLES_PER_BIT cycles, then go to DATA with bit index 0.
- DATA:
  - uart_txd = data[bit index], held CYCLES_PER_BIT cycles per bit, LSB first.
  - After bit PAYLOAD_BITS-1, go to STOP.
- STOP:
  - uart_txd=1 for STOP_BITS*CYCLES_PER_BIT cycles, then go to IDLE and clear busy.
- Frame timing: total frame = (1+PAYLOAD_BITS+STOP_BITS)*CYCLES_PER_BIT cycles = 52080 at defaults. uart_txd changes only on bit boundaries.
- Busy gap: busy stays low in IDLE for at least one full cycle between frames, even if uart_tx_en is held high continuously. A continuously-high en then produces back-to-back frames separated by exactly one idle cycle.
- uart_tx_en and uart_tx_data are ignored while busy=1. The data captured at acceptance is the only data sent; later changes to uart_tx_data do not affect the frame in flight.
- Cycle counter: width $clog2(CYCLES_PER_BIT+1). Resets to 0 at every bit boundary. No wrap within a bit.
- Bit counter: width $clog2(PAYLOAD_BITS).
- Simultaneous reset and en: reset wins; nothing is latched.

Decomposition:
- Shared package uart_pkg holds:
  - state enum (IDLE/START/DATA/STOP);
  - default BIT_RATE and CLK_HZ constants;
  - the CYCLES_PER_BIT helper function.
- The uart_rx block reuses this package.
- No sub-module is required. A baud-tick counter may optionally be factored out as uart_baud_cnt; the tick pulses when the count reaches CYCLES_PER_BIT-1.

Test Plan:
- Reset: hold resetn=1 for 3 cycles, then release -> uart_txd=1 and busy=0 throughout. Nothing is sent while en=0.
- Single byte 0xA5: one-cycle en pulse.
  - uart_txd sequence is 0 | 1,0,1,0,0,1,0,1 | 1, each level lasting 5208 cycles.
  - busy is high for exactly 52080 cycles.
- Byte 0x00 then 0xFF with en held high:
  - two consecutive frames with exactly one idle cycle between them (busy=0, txd=1);
  - payloads all-0 and all-1 verified.
- Data change mid-frame: accept 0x3C, then drive uart_tx_data=0xC3 and en=1 during DATA -> the frame carries 0x3C; 0xC3 is sent only after busy falls.
- Reset mid-frame: assert resetn during bit 4 of 0x55 -> uart_txd=1 and busy=0 on the next edge. The next accepted byte 0x81 is transmitted correctly.
- Random regression: 20 random bytes, each sent after waiting for busy=0 -> a sampling monitor at bit centres reconstructs every byte and finds a valid start and stop bit in each frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: line states, default rates and bit-period helper.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DEFAULT_BIT_RATE = 9600;
    localparam int DEFAULT_CLK_HZ   = 50000000;

    function automatic int cycles_per_bit(input int clk_hz, input int bit_rate);
        return clk_hz / bit_rate;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with enable/busy handshake and registered TX line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int BIT_RATE     = DEFAULT_BIT_RATE,
    parameter int CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int PAYLOAD_BITS = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    uart_tx_en,
    input  logic [PAYLOAD_BITS-1:0] uart_tx_data,
    output logic                    uart_tx_busy,
    output logic                    uart_txd
);

    localparam int CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
    localparam int CW = $clog2(CYCLES_PER_BIT + 1);
    localparam int BW = $clog2(PAYLOAD_BITS);

    state_t                  state_q, state_n;
    logic [CW-1:0]           cyc_q, cyc_n;
    logic [BW-1:0]           bit_q, bit_n;
    logic [PAYLOAD_BITS-1:0] data_q, data_n;
    logic                    txd_q, txd_n;
    logic                    last_cyc;

    always_ff @(posedge clk) begin
        if (resetn) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            data_q  <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_n;
            cyc_q   <= cyc_n;
            bit_q   <= bit_n;
            data_q  <= data_n;
            txd_q   <= txd_n;
        end
    end

    assign last_cyc = (cyc_q == CW'(CYCLES_PER_BIT - 1));

    always_comb begin
        state_n = state_q;
        cyc_n   = cyc_q;
        bit_n   = bit_q;
        data_n  = data_q;
        txd_n   = txd_q;
        unique case (state_q)
            IDLE: begin
                txd_n = 1'b1;
                if (uart_tx_en) begin
                    state_n = START;
                    data_n  = uart_tx_data;
                    txd_n   = 1'b0;
                    cyc_n   = '0;
                    bit_n   = '0;
                end
            end
            START: begin
                if (last_cyc) begin
                    state_n = DATA;
                    cyc_n   = '0;
                    bit_n   = '0;
                    txd_n   = data_q[0];
                end else begin
                    cyc_n = cyc_q + CW'(1);
                end
            end
            DATA: begin
                if (last_cyc) begin
                    cyc_n = '0;
                    if (bit_q == BW'(PAYLOAD_BITS - 1)) begin
                        state_n = STOP;
                        bit_n   = '0;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n  = bit_q + BW'(1);
                        data_n = data_q >> 1;
                        txd_n  = data_n[0];
                    end
                end else begin
                    cyc_n = cyc_q + CW'(1);
                end
            end
            STOP: begin
                if (last_cyc) begin
                    cyc_n = '0;
                    // Returning to IDLE guarantees one non-busy cycle between frames.
                    if (bit_q == BW'(STOP_BITS - 1)) begin
                        state_n = IDLE;
                        bit_n   = '0;
                        txd_n   = 1'b1;
                    end else begin
                        bit_n = bit_q + BW'(1);
                    end
                end else begin
                    cyc_n = cyc_q + CW'(1);
                end
            end
        endcase
    end

    assign uart_tx_busy = (state_q != IDLE);
    assign uart_txd     = txd_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at a shortened bit period.
module tb_uart_tx;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       uart_tx_en = 1'b0;
    logic [7:0] uart_tx_data = 8'h00;
    logic       uart_tx_busy;
    logic       uart_txd;

    int checks = 0;
    int failures = 0;

    uart_tx #(
        .BIT_RATE(10),
        .CLK_HZ(80),
        .PAYLOAD_BITS(8),
        .STOP_BITS(1)
    ) dut (
        .clk(clk),
        .resetn(resetn),
        .uart_tx_en(uart_tx_en),
        .uart_tx_data(uart_tx_data),
        .uart_tx_busy(uart_tx_busy),
        .uart_txd(uart_txd)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_txd"}, 32'(uart_txd), 32'd1);
        chk({tag, "_busy"}, 32'(uart_tx_busy), 32'd0);
    endtask

    // Called just after the accepting edge; checks every cycle of the frame.
    task automatic check_frame(input string tag, input logic [7:0] b,
                               input bit late, input logic [7:0] late_data);
        logic lvl;
        for (int i = 0; i < 10; i++) begin
            lvl = (i == 0) ? 1'b0 : (i == 9) ? 1'b1 : b[i-1];
            for (int c = 0; c < CPB; c++) begin
                if (late && i == 4 && c == 2) begin
                    uart_tx_data = late_data;
                    uart_tx_en = 1'b1;
                end
                chk($sformatf("%s_b%0d_c%0d_txd", tag, i, c), 32'(uart_txd), 32'(lvl));
                chk($sformatf("%s_b%0d_c%0d_busy", tag, i, c), 32'(uart_tx_busy), 32'd1);
                tick();
            end
        end
        chk_idle({tag, "_end"});
    endtask

    task automatic rx_frame(input int n, input logic [7:0] b);
        logic [9:0] s;
        int w;
        s = '0;
        for (int k = 0; k < 10 * CPB; k++) begin
            if (k % CPB == CPB / 2) s[k / CPB] = uart_txd;
            tick();
        end
        chk($sformatf("rnd%0d_start", n), 32'(s[0]), 32'd0);
        chk($sformatf("rnd%0d_stop", n), 32'(s[9]), 32'd1);
        chk($sformatf("rnd%0d_byte", n), 32'(s[8:1]), 32'(b));
        w = 0;
        while (uart_tx_busy && w < 4) begin
            tick();
            w++;
        end
        chk($sformatf("rnd%0d_busy_timeout", n), 32'(uart_tx_busy), 32'd0);
    endtask

    initial begin
        logic [7:0] r;

        // Reset held three cycles, then idle with en low.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_idle($sformatf("rst%0d", i));
        end
        resetn = 1'b0;
        chk("cpb", 32'(dut.CYCLES_PER_BIT), 32'd8);
        for (int i = 0; i < 20; i++) begin
            tick();
            chk_idle($sformatf("idle%0d", i));
        end

        // Single 0xA5 with a one-cycle enable pulse.
        uart_tx_en = 1'b1;
        uart_tx_data = 8'hA5;
        tick();
        uart_tx_en = 1'b0;
        check_frame("a5", 8'hA5, 1'b0, 8'h00);
        tick();
        chk_idle("a5_after");

        // 0x00 then 0xFF back to back with en held high.
        uart_tx_en = 1'b1;
        uart_tx_data = 8'h00;
        tick();
        uart_tx_data = 8'hFF;
        check_frame("b00", 8'h00, 1'b0, 8'h00);
        tick();
        uart_tx_en = 1'b0;
        check_frame("bff", 8'hFF, 1'b0, 8'h00);

        // Data change during DATA must not disturb the frame in flight.
        uart_tx_en = 1'b1;
        uart_tx_data = 8'h3C;
        tick();
        uart_tx_en = 1'b0;
        check_frame("d3c", 8'h3C, 1'b1, 8'hC3);
        tick();
        uart_tx_en = 1'b0;
        check_frame("dc3", 8'hC3, 1'b0, 8'h00);

        // Reset during bit 4 of 0x55.
        uart_tx_en = 1'b1;
        uart_tx_data = 8'h55;
        tick();
        uart_tx_en = 1'b0;
        for (int i = 0; i < 5 * CPB + 4; i++) tick();
        chk("mid_txd_b4", 32'(uart_txd), 32'd1);
        chk("mid_busy_b4", 32'(uart_tx_busy), 32'd1);
        resetn = 1'b1;
        tick();
        chk_idle("midrst");
        resetn = 1'b0;
        tick();
        chk_idle("midrst_rel");
        uart_tx_en = 1'b1;
        uart_tx_data = 8'h81;
        tick();
        uart_tx_en = 1'b0;
        check_frame("x81", 8'h81, 1'b0, 8'h00);

        // Reset and enable together: nothing is latched.
        resetn = 1'b1;
        uart_tx_en = 1'b1;
        uart_tx_data = 8'hAA;
        tick();
        resetn = 1'b0;
        uart_tx_en = 1'b0;
        chk_idle("rst_en");
        tick();
        chk_idle("rst_en_next");

        // Random bytes reconstructed at bit centres.
        for (int n = 0; n < 20; n++) begin
            r = 8'($urandom_range(0, 255));
            uart_tx_en = 1'b1;
            uart_tx_data = r;
            tick();
            uart_tx_en = 1'b0;
            rx_frame(n, r);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
